// File: rtl/shift_right_seq.sv
// ============================================================================
// Module   : shift_right_seq
// Function : Multi-cycle 32-bit right shifter (SRL/SRA/SRLV/SRAV) with a
//            start/busy/done handshake. Optional macro SHIFT_RIGHT_STEP4_EN
//            enables 4-position steps while at least 4 positions remain.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_right_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [4:0]  shamt,
   input  logic        arith,
   output logic [31:0] O,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [31:0] work, work_next;
   logic [4:0]  count, count_next;
   logic        arith_lat, arith_next;
   logic [31:0] result_next;
   logic        fill;

   // busy/done decode straight from the state so reset clears them at once
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // The sign bit never changes under arithmetic fill, so work[31] always
   // equals the sign of the original operand.
   assign fill = arith_lat & work[31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         work      <= 32'h0000_0000;
         count     <= 5'd0;
         arith_lat <= 1'b0;
         O         <= 32'h0000_0000;
      end else begin
         state     <= state_next;
         work      <= work_next;
         count     <= count_next;
         arith_lat <= arith_next;
         O         <= result_next;
      end
   end

   always_comb begin
      state_next  = state;
      work_next   = work;
      count_next  = count;
      arith_next  = arith_lat;
      result_next = O;

      case (state)
         IDLE: begin
            if (start) begin
               work_next  = A;
               count_next = shamt;
               arith_next = arith;
               if (shamt == 5'd0) begin
                  result_next = A;
                  state_next  = DONE;
               end else begin
                  state_next  = SHIFT;
               end
            end
         end

         SHIFT: begin
`ifdef SHIFT_RIGHT_STEP4_EN
            if (count >= 5'd4) begin
               work_next  = {{4{fill}}, work[31:4]};
               count_next = count - 5'd4;
            end else begin
               work_next  = {fill, work[31:1]};
               count_next = count - 5'd1;
            end
`else
            work_next  = {fill, work[31:1]};
            count_next = count - 5'd1;
`endif
            // O is loaded only on the step that finishes the shift
            if (count_next == 5'd0) begin
               result_next = work_next;
               state_next  = DONE;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire
